// File: rtl/bster_pkg.sv
// -----------------------------------------------------------------------------
// bster_pkg
// Shared types and constants for the bster command arbiter slice.
//   src_id_t           : identifies which requester issued a command (1 bit)
//   NUM_SRC            : number of requesters feeding the arbiter
//   OUTSTD_DEPTH_DFLT  : default number of commands allowed in flight
//   other_src()        : the requester that is not the given one
// -----------------------------------------------------------------------------
package bster_pkg;

   typedef logic [0:0] src_id_t;

   localparam int      NUM_SRC           = 2;
   localparam int      OUTSTD_DEPTH_DFLT = 8;

   localparam src_id_t SRC0 = 1'b0;
   localparam src_id_t SRC1 = 1'b1;

   // With two requesters the round-robin successor is simply the other one.
   function automatic src_id_t other_src(input src_id_t s);
      return ~s;
   endfunction

endpackage

// File: rtl/bster_id_fifo.sv
// -----------------------------------------------------------------------------
// bster_id_fifo
// Synchronous FIFO that remembers, in issue order, which requester owns each
// command in flight. Pushes while full and pops while empty are ignored; a
// push and a pop in the same cycle both take effect and leave count unchanged.
// Ports:
//   aclk, areset  : clock, asynchronous active-high reset (empties the FIFO)
//   push, din     : write one entry
//   pop, dout     : dout is the head entry, pop removes it
//   full, empty   : occupancy flags, derived from the registered count
//   count         : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module bster_id_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge aclk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bster_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// bster_cmd_arbiter
// Merges two command streams into one towards bster with round-robin
// arbitration and routes bster's in-order completions back to the requester
// that issued the matching command.
// Ports:
//   aclk, areset           : clock, asynchronous active-high reset
//   s0_cmd_*, s1_cmd_*     : requester command streams (sinks)
//   cmd_*                  : merged, registered command stream (source)
//   cpl_*                  : in-order completion stream from bster (sink)
//   s0_cpl_*, s1_cpl_*     : routed completion streams (sources)
//   outstanding            : commands accepted whose completion is not yet routed
//   err_orphan_cpl         : sticky, a completion arrived with nothing in flight
//
// Handshake semantics on every stream: a beat transfers on a rising edge where
// tvalid and tready are both 1. tvalid never depends on tready. tready may
// depend on tvalid (the command readies follow the grant, which follows the
// valids). A source holds tvalid and tdata stable until the beat transfers.
// -----------------------------------------------------------------------------
module bster_cmd_arbiter
   import bster_pkg::*;
#(
   parameter int AXI4S_WIDTH  = 128,
   parameter int OUTSTD_DEPTH = OUTSTD_DEPTH_DFLT
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          s0_cmd_tvalid,
   output logic                          s0_cmd_tready,
   input  logic [AXI4S_WIDTH-1:0]        s0_cmd_tdata,
   input  logic                          s1_cmd_tvalid,
   output logic                          s1_cmd_tready,
   input  logic [AXI4S_WIDTH-1:0]        s1_cmd_tdata,
   output logic                          cmd_tvalid,
   input  logic                          cmd_tready,
   output logic [AXI4S_WIDTH-1:0]        cmd_tdata,
   input  logic                          cpl_tvalid,
   output logic                          cpl_tready,
   input  logic [AXI4S_WIDTH-1:0]        cpl_tdata,
   output logic                          s0_cpl_tvalid,
   input  logic                          s0_cpl_tready,
   output logic [AXI4S_WIDTH-1:0]        s0_cpl_tdata,
   output logic                          s1_cpl_tvalid,
   input  logic                          s1_cpl_tready,
   output logic [AXI4S_WIDTH-1:0]        s1_cpl_tdata,
   output logic [$clog2(OUTSTD_DEPTH):0] outstanding,
   output logic                          err_orphan_cpl
);

   localparam int CW = $clog2(OUTSTD_DEPTH) + 1;

   // Output stage and arbitration state
   logic                   out_valid;
   logic [AXI4S_WIDTH-1:0] out_data;
   src_id_t                rr_ptr;      // requester that wins a tie next
   logic                   orphan_q;

   // ID FIFO interface
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CW-1:0]          fifo_count;
   src_id_t                head_id;
   logic                   cpl_pop;

   // Arbitration
   logic                   grant_valid;
   src_id_t                grant_id;
   logic [AXI4S_WIDTH-1:0] grant_data;
   logic                   can_accept;
   logic                   accept;
   logic                   cpl_orphan;

   always_comb begin
      grant_valid = s0_cmd_tvalid || s1_cmd_tvalid;
      // A lone requester wins regardless of the pointer; on a tie the
      // pointer decides.
      if (s0_cmd_tvalid && s1_cmd_tvalid) grant_id = rr_ptr;
      else if (s1_cmd_tvalid)             grant_id = SRC1;
      else                                grant_id = SRC0;
      grant_data = (grant_id == SRC1) ? s1_cmd_tdata : s0_cmd_tdata;

      // fifo_full comes from the registered count, so a completion popping
      // in this same cycle does not open a slot until the next cycle.
      can_accept    = !areset && (!out_valid || cmd_tready) && !fifo_full;
      s0_cmd_tready = can_accept && s0_cmd_tvalid && (grant_id == SRC0);
      s1_cmd_tready = can_accept && s1_cmd_tvalid && (grant_id == SRC1);
      accept        = can_accept && grant_valid;
   end

   // Completion routing: purely combinational pass-through to the owner at
   // the FIFO head. With nothing in flight the beat is swallowed and flagged.
   always_comb begin
      s0_cpl_tvalid = 1'b0;
      s1_cpl_tvalid = 1'b0;
      s0_cpl_tdata  = cpl_tdata;
      s1_cpl_tdata  = cpl_tdata;
      cpl_tready    = 1'b0;
      cpl_orphan    = 1'b0;
      cpl_pop       = 1'b0;
      if (!areset) begin
         if (fifo_empty) begin
            cpl_tready = 1'b1;
            cpl_orphan = cpl_tvalid;
         end else if (head_id == SRC0) begin
            s0_cpl_tvalid = cpl_tvalid;
            cpl_tready    = s0_cpl_tready;
         end else begin
            s1_cpl_tvalid = cpl_tvalid;
            cpl_tready    = s1_cpl_tready;
         end
         cpl_pop = cpl_tvalid && cpl_tready && !fifo_empty;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         rr_ptr    <= SRC0;
         orphan_q  <= 1'b0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            rr_ptr    <= other_src(grant_id);
         end else if (cmd_tready) begin
            out_valid <= 1'b0;
         end
         if (cpl_orphan) orphan_q <= 1'b1;
      end
   end

   bster_id_fifo #(
      .WIDTH (1),
      .DEPTH (OUTSTD_DEPTH)
   ) u_id_fifo (
      .aclk   (aclk),
      .areset (areset),
      .push   (accept),
      .din    (grant_id),
      .pop    (cpl_pop),
      .dout   (head_id),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   assign cmd_tvalid     = out_valid;
   assign cmd_tdata      = out_data;
   assign outstanding    = fifo_count;
   assign err_orphan_cpl = orphan_q;

endmodule

// File: tb/tb_bster_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bster_cmd_arbiter
// Self-checking bench for bster_cmd_arbiter. A reference model (a pending-beat
// slot, a queue of owner IDs, the last granted requester and a sticky orphan
// flag) predicts every output each cycle from the arbitration and routing
// rules. Directed scenarios are followed by randomized phases.
// -----------------------------------------------------------------------------
module tb_bster_cmd_arbiter;

   localparam int W     = 128;
   localparam int DEPTH = 8;
   localparam int OW    = $clog2(DEPTH) + 1;

   // ---------------- clock / reset ----------------
   logic aclk = 1'b0;
   logic areset = 1'b0;
   always #5 aclk = ~aclk;

   logic          s0_cmd_tvalid, s0_cmd_tready;
   logic [W-1:0]  s0_cmd_tdata;
   logic          s1_cmd_tvalid, s1_cmd_tready;
   logic [W-1:0]  s1_cmd_tdata;
   logic          cmd_tvalid, cmd_tready;
   logic [W-1:0]  cmd_tdata;
   logic          cpl_tvalid, cpl_tready;
   logic [W-1:0]  cpl_tdata;
   logic          s0_cpl_tvalid, s0_cpl_tready;
   logic [W-1:0]  s0_cpl_tdata;
   logic          s1_cpl_tvalid, s1_cpl_tready;
   logic [W-1:0]  s1_cpl_tdata;
   logic [OW-1:0] outstanding;
   logic          err_orphan_cpl;

   bster_cmd_arbiter #(.AXI4S_WIDTH(W), .OUTSTD_DEPTH(DEPTH)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .s0_cmd_tvalid  (s0_cmd_tvalid),
      .s0_cmd_tready  (s0_cmd_tready),
      .s0_cmd_tdata   (s0_cmd_tdata),
      .s1_cmd_tvalid  (s1_cmd_tvalid),
      .s1_cmd_tready  (s1_cmd_tready),
      .s1_cmd_tdata   (s1_cmd_tdata),
      .cmd_tvalid     (cmd_tvalid),
      .cmd_tready     (cmd_tready),
      .cmd_tdata      (cmd_tdata),
      .cpl_tvalid     (cpl_tvalid),
      .cpl_tready     (cpl_tready),
      .cpl_tdata      (cpl_tdata),
      .s0_cpl_tvalid  (s0_cpl_tvalid),
      .s0_cpl_tready  (s0_cpl_tready),
      .s0_cpl_tdata   (s0_cpl_tdata),
      .s1_cpl_tvalid  (s1_cpl_tvalid),
      .s1_cpl_tready  (s1_cpl_tready),
      .s1_cpl_tdata   (s1_cpl_tdata),
      .outstanding    (outstanding),
      .err_orphan_cpl (err_orphan_cpl)
   );

   // ---------------- scoreboard / reference model ----------------
   int           n_cmp = 0;
   int           n_err = 0;
   logic         m_pend_valid;
   logic [W-1:0] m_pend_data;
   int           m_last_grant;
   int           m_id_q[$];
   logic         m_orphan;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_pend_valid = 1'b0;
      m_pend_data  = '0;
      m_last_grant = 1;   // so requester 0 wins the first tie
      m_id_q.delete();
      m_orphan     = 1'b0;
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Entered and left at posedge+1. Drives inputs, lets logic settle, checks
   // every output against the model, advances the model, then waits a clock.
   task automatic step(input logic s0v, input logic [W-1:0] s0d,
                       input logic s1v, input logic [W-1:0] s1d,
                       input logic crdy,
                       input logic cv, input logic [W-1:0] cd,
                       input logic r0, input logic r1);
      int   pref, gsrc;
      logic can, e_r0, e_r1, e_crdy, e_v0, e_v1;
      s0_cmd_tvalid = s0v; s0_cmd_tdata = s0d;
      s1_cmd_tvalid = s1v; s1_cmd_tdata = s1d;
      cmd_tready    = crdy;
      cpl_tvalid    = cv;  cpl_tdata = cd;
      s0_cpl_tready = r0;  s1_cpl_tready = r1;
      #1;
      pref = (m_last_grant == 0) ? 1 : 0;
      if (s0v && s1v) gsrc = pref;
      else if (s1v)   gsrc = 1;
      else            gsrc = 0;
      can  = (!m_pend_valid || crdy) && (m_id_q.size() < DEPTH);
      e_r0 = can && s0v && (gsrc == 0);
      e_r1 = can && s1v && (gsrc == 1);
      if (m_id_q.size() == 0) begin
         e_crdy = 1'b1; e_v0 = 1'b0; e_v1 = 1'b0;
      end else if (m_id_q[0] == 0) begin
         e_crdy = r0; e_v0 = cv; e_v1 = 1'b0;
      end else begin
         e_crdy = r1; e_v0 = 1'b0; e_v1 = cv;
      end

      check_eq("cmd_tvalid", W'(cmd_tvalid), W'(m_pend_valid));
      if (m_pend_valid) check_eq("cmd_tdata", cmd_tdata, m_pend_data);
      check_eq("s0_cmd_tready", W'(s0_cmd_tready), W'(e_r0));
      check_eq("s1_cmd_tready", W'(s1_cmd_tready), W'(e_r1));
      check_eq("outstanding", W'(outstanding), W'(m_id_q.size()));
      check_eq("err_orphan_cpl", W'(err_orphan_cpl), W'(m_orphan));
      check_eq("cpl_tready", W'(cpl_tready), W'(e_crdy));
      check_eq("s0_cpl_tvalid", W'(s0_cpl_tvalid), W'(e_v0));
      check_eq("s1_cpl_tvalid", W'(s1_cpl_tvalid), W'(e_v1));
      if (e_v0) check_eq("s0_cpl_tdata", s0_cpl_tdata, cd);
      if (e_v1) check_eq("s1_cpl_tdata", s1_cpl_tdata, cd);

      // Completion decided on pre-cycle occupancy, then the command side.
      if (cv && e_crdy) begin
         if (m_id_q.size() == 0) m_orphan = 1'b1;
         else void'(m_id_q.pop_front());
      end
      if (m_pend_valid && crdy) m_pend_valid = 1'b0;
      if (e_r0 || e_r1) begin
         m_pend_valid = 1'b1;
         m_pend_data  = e_r0 ? s0d : s1d;
         m_id_q.push_back(gsrc);
         m_last_grant = gsrc;
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, '0, 1, 0, '0, 1, 1);
   endtask

   // Flush the output stage and complete everything in flight (bounded).
   task automatic drain();
      for (int i = 0; i < 4 * DEPTH; i++) begin
         if (m_id_q.size() == 0 && !m_pend_valid) break;
         step(0, '0, 0, '0, 1, m_id_q.size() > 0, rand_data(), 1, 1);
      end
      check_eq("drain_done", W'(m_id_q.size()), W'(0));
   endtask

   // Reset asserted mid-cycle; outputs must clear immediately.
   task automatic do_reset();
      #2;
      areset = 1'b1;
      s0_cmd_tvalid = 1'b1; s1_cmd_tvalid = 1'b1; cmd_tready = 1'b0;
      cpl_tvalid = 1'b1; s0_cpl_tready = 1'b1; s1_cpl_tready = 1'b1;
      cpl_tdata = rand_data();
      model_reset();
      for (int k = 0; k < 2; k++) begin
         #1;
         check_eq("rst_cmd_tvalid", W'(cmd_tvalid), '0);
         check_eq("rst_cmd_tdata", cmd_tdata, '0);
         check_eq("rst_s0_cmd_tready", W'(s0_cmd_tready), '0);
         check_eq("rst_s1_cmd_tready", W'(s1_cmd_tready), '0);
         check_eq("rst_cpl_tready", W'(cpl_tready), '0);
         check_eq("rst_s0_cpl_tvalid", W'(s0_cpl_tvalid), '0);
         check_eq("rst_s1_cpl_tvalid", W'(s1_cpl_tvalid), '0);
         check_eq("rst_outstanding", W'(outstanding), '0);
         check_eq("rst_err_orphan", W'(err_orphan_cpl), '0);
         @(posedge aclk);
      end
      @(negedge aclk);
      areset = 1'b0;
      s0_cmd_tvalid = 1'b0; s1_cmd_tvalid = 1'b0; cpl_tvalid = 1'b0;
      @(posedge aclk);
      #1;
   endtask

   task automatic rand_phase(input int cycles, input int p_cmd, input int p_rdy,
                             input int p_cpl, input int p_crdy);
      for (int i = 0; i < cycles; i++)
         step($urandom_range(99) < p_cmd, rand_data(),
              $urandom_range(99) < p_cmd, rand_data(),
              $urandom_range(99) < p_rdy,
              $urandom_range(99) < p_cpl, rand_data(),
              $urandom_range(99) < p_crdy, $urandom_range(99) < p_crdy);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      s0_cmd_tvalid = 0; s0_cmd_tdata = '0; s1_cmd_tvalid = 0; s1_cmd_tdata = '0;
      cmd_tready = 0; cpl_tvalid = 0; cpl_tdata = '0; s0_cpl_tready = 0; s1_cpl_tready = 0;
      model_reset();
      do_reset();

      // Both requesters always valid: output alternates s0,s1,s0,...
      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] exp_alt;
         if (i > 0) begin
            exp_alt = (i % 2 == 1) ? W'(32'h100 + i - 1) : W'(32'h200 + i - 1);
            check_eq("alternate_cmd_tdata", cmd_tdata, exp_alt);
         end
         step(1, W'(32'h100 + i), 1, W'(32'h200 + i), 1, 0, '0, 1, 1);
      end
      drain();

      // Lone requester 1 with 0xA5: visible one cycle after the handshake.
      step(0, '0, 1, W'(8'hA5), 1, 0, '0, 1, 1);
      check_eq("lone_s1_tvalid", W'(cmd_tvalid), W'(1));
      check_eq("lone_s1_tdata", cmd_tdata, W'(8'hA5));
      drain();

      // Downstream stall for 5 cycles: beat held, no acceptance.
      step(1, W'(32'h5101), 0, '0, 0, 0, '0, 1, 1);
      for (int i = 0; i < 5; i++) step(1, W'(32'h5102), 1, W'(32'h5103), 0, 0, '0, 1, 1);
      check_eq("stall_hold_tdata", cmd_tdata, W'(32'h5101));
      drain();

      // Fill to the outstanding limit, then one completion frees a slot.
      for (int i = 0; i < DEPTH; i++) step(1, W'(32'h800 + i), 0, '0, 1, 0, '0, 1, 1);
      step(1, W'(32'h8FF), 1, W'(32'h9FF), 1, 0, '0, 1, 1);
      check_eq("full_outstanding", W'(outstanding), W'(DEPTH));
      step(1, W'(32'h8FF), 1, W'(32'h9FF), 1, 1, W'(32'hC0), 1, 1);
      check_eq("after_pop_outstanding", W'(outstanding), W'(DEPTH - 1));
      step(1, W'(32'h8FF), 1, W'(32'h9FF), 1, 0, '0, 1, 1);
      check_eq("resume_outstanding", W'(outstanding), W'(DEPTH));
      drain();

      // Issue s0,s1,s1 then completions 1,2,3 with a requester-1 stall.
      step(1, W'(32'h10), 0, '0, 1, 0, '0, 1, 1);
      step(0, '0, 1, W'(32'h11), 1, 0, '0, 1, 1);
      step(0, '0, 1, W'(32'h12), 1, 0, '0, 1, 1);
      step(0, '0, 0, '0, 1, 0, '0, 1, 1);
      step(0, '0, 0, '0, 1, 1, W'(1), 1, 1);
      step(0, '0, 0, '0, 1, 1, W'(2), 1, 0);
      check_eq("stalled_outstanding", W'(outstanding), W'(2));
      step(0, '0, 0, '0, 1, 1, W'(2), 1, 1);
      step(0, '0, 0, '0, 1, 1, W'(3), 1, 1);
      check_eq("routed_all_outstanding", W'(outstanding), W'(0));

      // Orphan completion: swallowed, flag sticky until reset.
      step(0, '0, 0, '0, 1, 1, W'(32'hDEAD), 0, 0);
      check_eq("orphan_set", W'(err_orphan_cpl), W'(1));
      idle(3);
      check_eq("orphan_sticky", W'(err_orphan_cpl), W'(1));
      do_reset();

      // Randomized traffic, including a reset in the middle of activity.
      rand_phase(300, 70, 80, 50, 90);
      rand_phase(300, 90, 90, 15, 80);
      do_reset();
      rand_phase(300, 50, 40, 80, 50);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
